// File: rtl/enigma_msg_sched.sv
// Per-message scheduler in front of the Enigma core: round-robin grant, rotor reset, letter
// streaming, pipeline drain, and channel/last tagging of the encoded letters.
module enigma_msg_sched #(
  parameter int unsigned CORE_LATENCY = 6,
  parameter int unsigned MAX_LEN      = 255
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [1:0]      req_i,
  input  logic [1:0][6:0] symb_i,
  input  logic [1:0]      symb_val_i,
  input  logic [1:0]      last_i,
  output logic [1:0]      ready_o,
  output logic            core_rotors_rst_o,
  output logic [6:0]      core_symb_o,
  output logic            core_symb_val_o,
  input  logic [6:0]      core_symb_i,
  input  logic            core_symb_val_i,
  output logic [6:0]      out_symb_o,
  output logic            out_val_o,
  output logic            out_ch_o,
  output logic            out_last_o,
  output logic            err_o
);

  localparam int unsigned CntW   = $clog2(MAX_LEN + 1);
  localparam int unsigned DrainW = $clog2(CORE_LATENCY + 2);

  typedef enum logic [1:0] {StIdle, StRotRst, StStream, StDrain} state_e;

  state_e              state_q;
  logic                gnt_q;
  logic                prio_q;
  logic [CntW-1:0]     cnt_q;
  logic [DrainW-1:0]   drain_q;
  logic                tag0_ch_q;
  logic                tag0_last_q;
  logic [CORE_LATENCY:1] tag_val_q;
  logic [CORE_LATENCY:1] tag_ch_q;
  logic [CORE_LATENCY:1] tag_last_q;

  logic [6:0] symb;
  logic       gnt_sel;
  logic       accept;
  logic       legal;
  logic       len_hit;
  logic       msg_end;

  always_comb begin
    symb    = symb_i[gnt_q];
    gnt_sel = (req_i == 2'b11) ? prio_q : req_i[1];
    accept  = symb_val_i[gnt_q] & ready_o[gnt_q];
    legal   = (symb >= 7'd1) && (symb <= 7'd26);
    // Only legal letters count towards the length limit.
    len_hit = legal && (cnt_q == CntW'(MAX_LEN - 1));
    msg_end = accept & (last_i[gnt_q] | len_hit);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q           <= StIdle;
      gnt_q             <= 1'b0;
      prio_q            <= 1'b0;
      cnt_q             <= '0;
      drain_q           <= '0;
      ready_o           <= 2'b00;
      core_rotors_rst_o <= 1'b0;
    end else begin
      core_rotors_rst_o <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (|req_i) begin
            gnt_q             <= gnt_sel;
            prio_q            <= ~gnt_sel;
            core_rotors_rst_o <= 1'b1;
            state_q           <= StRotRst;
          end
        end
        StRotRst: begin
          cnt_q   <= '0;
          ready_o <= gnt_q ? 2'b10 : 2'b01;
          state_q <= StStream;
        end
        StStream: begin
          if (accept && legal) cnt_q <= cnt_q + 1'b1;
          if (msg_end) begin
            ready_o <= 2'b00;
            drain_q <= DrainW'(CORE_LATENCY + 1);
            state_q <= StDrain;
          end
        end
        StDrain: begin
          drain_q <= drain_q - 1'b1;
          if (drain_q == DrainW'(1)) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Core input register, tag delay line aligned to the core latency, and output register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      core_symb_o     <= '0;
      core_symb_val_o <= 1'b0;
      tag0_ch_q       <= 1'b0;
      tag0_last_q     <= 1'b0;
      tag_val_q       <= '0;
      tag_ch_q        <= '0;
      tag_last_q      <= '0;
      out_symb_o      <= '0;
      out_val_o       <= 1'b0;
      out_ch_o        <= 1'b0;
      out_last_o      <= 1'b0;
      err_o           <= 1'b0;
    end else begin
      core_symb_o     <= symb;
      core_symb_val_o <= accept & legal;
      tag0_ch_q       <= gnt_q;
      tag0_last_q     <= accept & legal & (last_i[gnt_q] | len_hit);
      tag_val_q[1]    <= core_symb_val_o;
      tag_ch_q[1]     <= tag0_ch_q;
      tag_last_q[1]   <= tag0_last_q;
      for (int i = 2; i <= int'(CORE_LATENCY); i++) begin
        tag_val_q[i]  <= tag_val_q[i-1];
        tag_ch_q[i]   <= tag_ch_q[i-1];
        tag_last_q[i] <= tag_last_q[i-1];
      end
      // Untagged core output (e.g. left over from an aborted message) is never forwarded.
      out_val_o <= core_symb_val_i & tag_val_q[CORE_LATENCY];
      if (core_symb_val_i) begin
        out_symb_o <= core_symb_i;
        out_ch_o   <= tag_ch_q[CORE_LATENCY];
        out_last_o <= tag_last_q[CORE_LATENCY];
      end
      if ((accept & ~legal) | (core_symb_val_i ^ tag_val_q[CORE_LATENCY])) err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_enigma_msg_sched.sv
// Directed bench for enigma_msg_sched (MAX_LEN=4 build) with a behavioural core model whose
// cipher depends on the letter index since the last rotor reset.
module tb_enigma_msg_sched;

  localparam int Lat = 6;

  logic            clk;
  logic            rst;
  logic [1:0]      req;
  logic [1:0][6:0] symb;
  logic [1:0]      symb_val;
  logic [1:0]      last;
  logic [1:0]      ready;
  logic            core_rotors_rst;
  logic [6:0]      core_symb;
  logic            core_symb_val;
  logic [6:0]      core_symb_in;
  logic            core_symb_val_in;
  logic [6:0]      out_symb;
  logic            out_val;
  logic            out_ch;
  logic            out_last;
  logic            err;

  enigma_msg_sched #(.CORE_LATENCY(Lat), .MAX_LEN(4)) u_dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .req_i            (req),
    .symb_i           (symb),
    .symb_val_i       (symb_val),
    .last_i           (last),
    .ready_o          (ready),
    .core_rotors_rst_o(core_rotors_rst),
    .core_symb_o      (core_symb),
    .core_symb_val_o  (core_symb_val),
    .core_symb_i      (core_symb_in),
    .core_symb_val_i  (core_symb_val_in),
    .out_symb_o       (out_symb),
    .out_val_o        (out_val),
    .out_ch_o         (out_ch),
    .out_last_o       (out_last),
    .err_o            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] enc(input logic [6:0] s, input int k);
    return 7'(((int'(s) - 1 + 3 + 5 * k) % 26) + 1);
  endfunction

  // Core model: fixed latency, key index restarts on every rotor reset.
  logic       p_val [1:Lat];
  logic [6:0] p_sym [1:Lat];
  int         key_k;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i <= Lat; i++) begin
        p_val[i] <= 1'b0;
        p_sym[i] <= 7'd0;
      end
      key_k <= 0;
    end else begin
      p_val[1] <= core_symb_val;
      p_sym[1] <= enc(core_symb, key_k);
      for (int i = 2; i <= Lat; i++) begin
        p_val[i] <= p_val[i-1];
        p_sym[i] <= p_sym[i-1];
      end
      if (core_rotors_rst) key_k <= 0;
      else if (core_symb_val) key_k <= key_k + 1;
    end
  end
  assign core_symb_val_in = p_val[Lat];
  assign core_symb_in     = p_sym[Lat];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [6:0] oq_sym[$];
  logic       oq_ch[$];
  logic       oq_last[$];
  int         oq_cyc[$];
  int         acc_cyc[$];
  int         rr_cnt;
  int         rr_cyc;
  int         overlap;

  always @(negedge clk) begin
    if (out_val) begin
      oq_sym.push_back(out_symb);
      oq_ch.push_back(out_ch);
      oq_last.push_back(out_last);
      oq_cyc.push_back(cyc);
    end
    if (core_rotors_rst) begin
      rr_cnt = rr_cnt + 1;
      rr_cyc = cyc;
    end
    if (ready == 2'b11) overlap = overlap + 1;
    if ((ready & symb_val) != 2'b00) acc_cyc.push_back(cyc);
  end

  int n_pass = 0;
  int n_tot  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tot = n_tot + 1;
    if (act == exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    oq_sym.delete();
    oq_ch.delete();
    oq_last.delete();
    oq_cyc.delete();
    acc_cyc.delete();
    rr_cnt  = 0;
    overlap = 0;
  endtask

  task automatic wait_ready(input logic [1:0] mask, output int got, output logic ok);
    ok  = 1'b0;
    got = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      if ((ready & mask) != 2'b00) begin
        ok  = 1'b1;
        got = cyc;
      end else begin
        step();
      end
    end
  endtask

  task automatic drive_msg(input logic c, input int n, input logic [0:5][6:0] l,
                           input logic [0:5] lf);
    for (int i = 0; i < n; i++) begin
      symb[c]     = l[i];
      symb_val[c] = 1'b1;
      last[c]     = lf[i];
      step();
    end
    symb_val[c] = 1'b0;
    last[c]     = 1'b0;
  endtask

  function automatic int all_outs();
    return int'({ready, core_rotors_rst, core_symb, core_symb_val, out_symb, out_val, out_ch,
                 out_last, err});
  endfunction

  typedef struct {
    logic            ch;
    int              n;
    logic [0:5][6:0] l;
    logic [0:5]      lf;
    int              exp_n;
    logic [0:3][6:0] es;
    logic [0:3]      el;
    logic            exp_err;
    logic            chk_lat;
  } vec_t;

  vec_t       vecs[5];
  logic [6:0] cont_exp[8];

  initial begin
    int   req_cyc;
    int   rdy_cyc;
    int   n0;
    logic ok;
    logic gch;

    vecs[0] = '{ch: 1'b0, n: 3, l: {7'd1, 7'd2, 7'd3, 7'd0, 7'd0, 7'd0}, lf: 6'b001000,
                exp_n: 3, es: {7'd4, 7'd10, 7'd16, 7'd0}, el: 4'b0010, exp_err: 1'b0,
                chk_lat: 1'b1};
    vecs[1] = '{ch: 1'b1, n: 4, l: {7'd20, 7'd21, 7'd22, 7'd23, 7'd0, 7'd0}, lf: 6'b000100,
                exp_n: 4, es: {7'd23, 7'd3, 7'd9, 7'd15}, el: 4'b0001, exp_err: 1'b0,
                chk_lat: 1'b0};
    vecs[2] = vecs[1];
    vecs[3] = '{ch: 1'b0, n: 4, l: {7'd5, 7'd0, 7'd27, 7'd9, 7'd0, 7'd0}, lf: 6'b000100,
                exp_n: 2, es: {7'd8, 7'd17, 7'd0, 7'd0}, el: 4'b0100, exp_err: 1'b1,
                chk_lat: 1'b0};
    // Length limit: six letters without last, only four accepted.
    vecs[4] = '{ch: 1'b0, n: 6, l: {7'd1, 7'd2, 7'd3, 7'd4, 7'd5, 7'd6}, lf: 6'b000000,
                exp_n: 4, es: {7'd4, 7'd10, 7'd16, 7'd22}, el: 4'b0001, exp_err: 1'b1,
                chk_lat: 1'b0};
    cont_exp = '{7'd13, 7'd19, 7'd14, 7'd20, 7'd15, 7'd21, 7'd16, 7'd22};

    rst      = 1'b1;
    req      = 2'b00;
    symb     = '0;
    symb_val = 2'b00;
    last     = 2'b00;
    clear_mon();
    repeat (3) step();
    check("reset_outputs", all_outs(), 0);
    rst = 1'b0;
    step();

    // Contention: both channels request continuously.
    clear_mon();
    req = 2'b11;
    for (int m = 0; m < 4; m++) begin
      wait_ready(2'b11, rdy_cyc, ok);
      check("cont_grant_seen", int'(ok), 1);
      gch = ready[1];
      check("cont_grant_order", int'(gch), m % 2);
      if (m == 3) req = 2'b00;
      drive_msg(gch, 2, {7'(10 + m), 7'(11 + m), 7'd0, 7'd0, 7'd0, 7'd0}, 6'b010000);
    end
    repeat (14) step();
    check("cont_rot_rst_pulses", rr_cnt, 4);
    check("cont_ready_overlap", overlap, 0);
    check("cont_out_count", oq_sym.size(), 8);
    for (int i = 0; i < 8 && i < oq_sym.size(); i++) begin
      check("cont_out_ch", int'(oq_ch[i]), (i / 2) % 2);
      check("cont_out_last", int'(oq_last[i]), i % 2);
      check("cont_out_symb", int'(oq_sym[i]), int'(cont_exp[i]));
    end

    for (int v = 0; v < 5; v++) begin
      clear_mon();
      req[vecs[v].ch] = 1'b1;
      req_cyc         = cyc;
      wait_ready(vecs[v].ch ? 2'b10 : 2'b01, rdy_cyc, ok);
      check("vec_ready_seen", int'(ok), 1);
      check("vec_ready_latency", rdy_cyc - req_cyc, 2);
      req[vecs[v].ch] = 1'b0;
      drive_msg(vecs[v].ch, vecs[v].n, vecs[v].l, vecs[v].lf);
      repeat (14) step();
      check("vec_rot_rst_pulses", rr_cnt, 1);
      check("vec_rot_rst_cycle", rr_cyc, req_cyc + 1);
      check("vec_out_count", oq_sym.size(), vecs[v].exp_n);
      for (int i = 0; i < vecs[v].exp_n && i < oq_sym.size(); i++) begin
        check("vec_out_symb", int'(oq_sym[i]), int'(vecs[v].es[i]));
        check("vec_out_ch", int'(oq_ch[i]), int'(vecs[v].ch));
        check("vec_out_last", int'(oq_last[i]), int'(vecs[v].el[i]));
        if (vecs[v].chk_lat && i < acc_cyc.size())
          check("vec_accept_to_out", oq_cyc[i] - acc_cyc[i], Lat + 2);
      end
      check("vec_err", int'(err), int'(vecs[v].exp_err));
      check("vec_ready_after", int'(ready), 0);
    end

    // Reset two cycles after the first accept aborts the message.
    clear_mon();
    req[0] = 1'b1;
    wait_ready(2'b01, rdy_cyc, ok);
    check("rst_ready_seen", int'(ok), 1);
    req[0] = 1'b0;
    symb[0]     = 7'd7;
    symb_val[0] = 1'b1;
    step();
    symb[0] = 7'd8;
    step();
    symb_val[0] = 1'b0;
    rst         = 1'b1;
    #1;
    check("rst_mid_outputs", all_outs(), 0);
    step();
    rst = 1'b0;
    n0  = oq_sym.size();
    repeat (15) step();
    check("rst_no_out", oq_sym.size() - n0, 0);
    check("rst_err_clear", int'(err), 0);
    check("rst_ready_idle", int'(ready), 0);
    req = 2'b11;
    wait_ready(2'b11, rdy_cyc, ok);
    check("rst_prio_zero", int'(ready), 1);
    req = 2'b00;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/enigma_msg_sched.md
# enigma_msg_sched

Message-level scheduler in front of the Enigma encryption core. It arbitrates two requester channels per whole message and pulses the core's rotor reset before each message so every message starts from the initial rotor key. It streams the granted channel's letters into the core, drains the core pipeline before the next message, and tags each encoded letter with its source channel and end-of-message flag. It sits between the host-side letter sources and the core's `rotors_rst_i` / `in_symb_*` / `out_symb_*` ports.

## Interface
- `CORE_LATENCY`, 6: cycles from core input-valid sample to core output-valid.
- `MAX_LEN`, 255: maximum letters per message. The message is force-ended on letter `MAX_LEN`.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `req_i`  in  2  per-channel "message pending".
- `symb_i`  in  2x7  per-channel letter, legal range 1..26.
- `symb_val_i`  in  2  per-channel letter valid.
- `last_i`  in  2  per-channel last letter of message; qualified by `symb_val_i`.
- `ready_o`  out  2  per-channel accept. At most one bit is high.
- `core_rotors_rst_o`  out  1  rotor reset pulse to the core.
- `core_symb_o`  out  7  letter to the core.
- `core_symb_val_o`  out  1  letter valid to the core.
- `core_symb_i`  in  7  encoded letter from the core.
- `core_symb_val_i`  in  1  encoded letter valid from the core.
- `out_symb_o`  out  7  encoded letter.
- `out_val_o`  out  1  encoded letter valid.
- `out_ch_o`  out  1  source channel of `out_symb_o`.
- `out_last_o`  out  1  `out_symb_o` is the last letter of its message.
- `err_o`  out  1  sticky error.

## Operation
- FSM states and transitions:
  - IDLE: if any `req_i` bit is high, grant and go to ROT_RST.
  - ROT_RST: `core_rotors_rst_o` = 1 for exactly this one cycle; go to STREAM.
  - STREAM: `ready_o[gnt]` = 1.
  - A letter is accepted when `symb_val_i[gnt] & ready_o[gnt]`.
  - On an accepted letter with `last_i[gnt]` = 1, or when the accepted-letter count reaches `MAX_LEN`, go to DRAIN.
  - DRAIN: a down-counter is loaded with `CORE_LATENCY+1`. Return to IDLE when it reaches 0.
- Arbitration is round-robin per message.
  - Pointer `prio` resets to 0. If both channels request, grant channel `prio`.
  - On grant of channel c, `prio` <= ~c.
  - `gnt` is held constant from ROT_RST through DRAIN.
- Core input is registered:
  - `core_symb_o` <= `symb_i[gnt]`.
  - `core_symb_val_o` <= accept & legal, where legal means 1 <= letter <= 26.
- Illegal letters are accepted (consumed) but not forwarded or counted, and they set `err_o`. An illegal letter carrying `last_i` still ends the message; no `out_last_o` is produced for that message.
- Tag delay line: `CORE_LATENCY` stages of {valid, ch, last}, shifted every cycle and loaded from the core-input register.
  - At stage `CORE_LATENCY` the tag aligns with `core_symb_val_i`.
  - `core_symb_val_i` without a valid tag, or a valid tag without `core_symb_val_i`, sets `err_o`.
- Output register: on `core_symb_val_i`, latch `out_symb_o`, `out_ch_o` and `out_last_o` from the core letter and the aligned tag. `out_val_o` pulses for 1 cycle.
- Letter counter width is `$clog2(MAX_LEN+1)`. It clears in ROT_RST.
- Inputs on the non-granted channel are ignored; it sees `ready_o` = 0.
- `req_i` dropping during STREAM has no effect. The message ends only on last or `MAX_LEN`.

## Timing
- Reset values: all outputs 0; FSM in IDLE; `prio` = 0; tag line cleared; `err_o` cleared. Only `rst_i` clears `err_o`.
- Asserting `rst_i` mid-message aborts the message. In-flight tags are discarded and no `out_val_o` is produced for them.
- Request to first `ready_o`:
  - `req_i` sampled in IDLE at cycle t.
  - `core_rotors_rst_o` high in cycle t+1.
  - `ready_o` high from cycle t+2.
- Letter accepted at cycle a:
  - `core_symb_val_o` high in cycle a+1.
  - `core_symb_val_i` high in cycle a+1+`CORE_LATENCY`.
  - `out_val_o` high in cycle a+2+`CORE_LATENCY`.
- `ready_o` falls in the cycle after the last-letter accept. No rotor reset pulse occurs while any tag is valid.
- Throughput: 1 letter/cycle in STREAM. Per-message overhead is 2 + (`CORE_LATENCY`+1) cycles.

## Test plan
- Single message: ch0 sends 3 letters (1, 2, 3) with last on 3 → exactly one `core_rotors_rst_o` pulse, then 3 `out_val_o` pulses with `out_ch_o` = 0 and `out_last_o` only on the third. Each output appears 8 cycles after its accept; `err_o` = 0.
- Contention: `req_i` = 2'b11 from reset, each channel sends 2-letter messages → grant order 0, 1, 0, 1. No `ready_o` overlap. A rotor reset pulse precedes each message, and outputs are never interleaved across channels.
- Key restart: the same 4-letter message sent twice on ch1 → identical `out_symb_o` sequences both times.
- Illegal letter: ch0 sends 5, 0, 27, 9 (last) → only 2 `out_val_o` pulses (5 and 9), with last on 9; `err_o` = 1 and stays 1.
- MAX_LEN=4 build: ch0 streams 6 letters without last → `ready_o` drops after letter 4 and `out_last_o` is set on output 4. Letters 5–6 are not accepted; ch0 must re-request.
- Reset mid-stream: `rst_i` pulsed 2 cycles after the first accept → all outputs 0, no further `out_val_o`, `prio` = 0, FSM in IDLE.
